// File: rtl/wallace_tree_pkg.sv
// Shared widths and layer sizing for the fp16 significand multiplier.
// Row counts per Wallace layer: 11 -> 8 -> 6 -> 4 -> 3 -> 2.
package wallace_tree_pkg;

  localparam int N_BITS = 11;
  localparam int P_BITS = 22;
  localparam int LAYERS = 5;

  typedef logic [N_BITS-1:0] operand_t;
  typedef logic [P_BITS-1:0] product_t;

  // Rows entering layer l (l = LAYERS is the CPA input).
  function automatic int row_cnt(input int l);
    int n;
    n = N_BITS;
    for (int k = 0; k < l; k++)
      n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

endpackage

// File: rtl/wallace_tree_full_adder.sv
// 3:2 carry-save cell used across all reduction layers.
// Ports: a, b, cin -> sum, cout.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/wallace_tree.sv
// Unsigned 11x11 Wallace-tree multiplier, product registered once.
// Ports: clk, rst (sync, active-high), a, b -> out (22-bit a*b).
module wallace_tree
  import wallace_tree_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BITS-1:0]  a,
  input  logic [N_BITS-1:0]  b,
  output logic [P_BITS-1:0]  out
);

  // rows[l][r]: row r entering layer l; slots past row_cnt(l) tie to 0.
  logic [P_BITS-1:0] rows [0:LAYERS][0:N_BITS-1];
  logic [P_BITS-1:0] cpa;

  genvar i, l, g, k;

  for (i = 0; i < N_BITS; i++) begin : g_pp
    assign rows[0][i] =
      {{(P_BITS-N_BITS){1'b0}}, a & {N_BITS{b[i]}}} << i;
  end

  for (l = 0; l < LAYERS; l++) begin : g_layer
    localparam int CUR = row_cnt(l);
    localparam int GRP = CUR / 3;
    localparam int REM = CUR % 3;
    localparam int NXT = 2 * GRP + REM;

    for (g = 0; g < GRP; g++) begin : g_grp
      logic [P_BITS-1:0] s;
      logic [P_BITS-2:0] c;

      for (k = 0; k < P_BITS - 1; k++) begin : g_fa
        full_adder u_fa (
          .a    (rows[l][3*g][k]),
          .b    (rows[l][3*g+1][k]),
          .cin  (rows[l][3*g+2][k]),
          .sum  (s[k]),
          .cout (c[k])
        );
      end

      // Top column's carry would land at bit 22; the product
      // never reaches it, so only the sum is formed.
      assign s[P_BITS-1] = rows[l][3*g][P_BITS-1]
                         ^ rows[l][3*g+1][P_BITS-1]
                         ^ rows[l][3*g+2][P_BITS-1];

      assign rows[l+1][2*g]   = s;
      assign rows[l+1][2*g+1] = {c, 1'b0};
    end

    for (k = 0; k < REM; k++) begin : g_pass
      assign rows[l+1][2*GRP+k] = rows[l][3*GRP+k];
    end

    for (k = NXT; k < N_BITS; k++) begin : g_tie
      assign rows[l+1][k] = '0;
    end
  end

  assign cpa = rows[LAYERS][0] + rows[LAYERS][1];

  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= cpa;
  end

endmodule

// File: tb/tb_wallace_tree.sv
// Self-checking bench for wallace_tree: scoreboard of a*b
// pushed at drive time, popped one cycle later.
module tb_wallace_tree;
  import wallace_tree_pkg::*;

  logic              clk;
  logic              rst;
  logic [N_BITS-1:0] a;
  logic [N_BITS-1:0] b;
  logic [P_BITS-1:0] out;

  int checks;
  int errors;

  logic [P_BITS-1:0] sb [$];

  wallace_tree dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [P_BITS-1:0] got,
                     input logic [P_BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one pair, push its expectation, clock, pop and check.
  task automatic step(input string tag, input int av,
                      input int bv, input logic r);
    logic [P_BITS-1:0] e;
    logic [P_BITS-1:0] x;
    a   = N_BITS'(av);
    b   = N_BITS'(bv);
    rst = r;
    x   = P_BITS'(av) * P_BITS'(bv);
    e   = r ? '0 : x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, out, 'x);
    end else begin
      chk(tag, out, sb.pop_front());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a = '0;
    b = '0;
    @(negedge clk);

    step("rst0", 1894, 1062, 1'b1);
    step("rst1", 1894, 1062, 1'b1);
    step("rst_rel", 1894, 1062, 1'b0);

    step("str0", 1894, 1062, 1'b0);
    step("str1", 194, 1162, 1'b0);
    step("str2", 190, 162, 1'b0);

    chk("const_a", 22'(2011428), 22'(1894 * 1062));

    step("max", 2047, 2047, 1'b0);
    chk("max_hex", out, 22'h3FF001);
    step("max_by1", 2047, 1, 1'b0);
    step("zero_a", 0, 2047, 1'b0);
    step("zero_b", 2047, 0, 1'b0);
    step("one_a", 1, 1365, 1'b0);

    for (int i = 0; i < N_BITS; i++)
      for (int j = 0; j < N_BITS; j++)
        step("sweep", 1 << i, 1 << j, 1'b0);

    for (int n = 0; n < 10000; n++) begin
      logic r;
      r = ($urandom_range(0, 49) == 0);
      step(r ? "rnd_rst" : "rnd",
           $urandom_range(0, 2047),
           $urandom_range(0, 2047), r);
    end

    chk("sb_drained", P_BITS'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
